// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control sequencer.
//   opcode_e : 3-bit instruction opcodes
//   state_e  : sequencer states
//   ALU_*    : alu_op encodings driven to the datapath
//   dec_t    : decoded control bundle produced by ctrl_decode
package ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_RROT  = 3'b001,
        OP_NAND  = 3'b010,
        OP_LOAD  = 3'b011,
        OP_STORE = 3'b100,
        OP_MOVE  = 3'b101,
        OP_BNE   = 3'b110,
        OP_SET   = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_RROT = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       writes_reg;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control bundle.
//   instr_i : latched opcode (OPW bits)
//   dec_o   : {alu_op, alu_src, is_load, is_store, is_branch, writes_reg}
// Address generation for LOAD/STORE uses base + immediate (ADD, alu_src=1).
// BNE passes the register operand through so the ALU zero flag reflects it.
// Opcodes with nonzero bits above bit 2 are NOPs: they pass through WB
// without writing the register file, but still advance the PC.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] instr_i,
    output dec_t           dec_o
);

    logic    nop;
    opcode_e op;

    always_comb begin
        nop              = ((instr_i >> 3) != '0);
        op               = opcode_e'(instr_i[2:0]);
        dec_o.alu_op     = ALU_PASS;
        dec_o.alu_src    = 1'b0;
        dec_o.is_load    = 1'b0;
        dec_o.is_store   = 1'b0;
        dec_o.is_branch  = 1'b0;
        dec_o.writes_reg = 1'b0;
        if (!nop) begin
            case (op)
                OP_ADD: begin
                    dec_o.alu_op     = ALU_ADD;
                    dec_o.writes_reg = 1'b1;
                end
                OP_RROT: begin
                    dec_o.alu_op     = ALU_RROT;
                    dec_o.writes_reg = 1'b1;
                end
                OP_NAND: begin
                    dec_o.alu_op     = ALU_NAND;
                    dec_o.writes_reg = 1'b1;
                end
                OP_LOAD: begin
                    dec_o.alu_op     = ALU_ADD;
                    dec_o.alu_src    = 1'b1;
                    dec_o.is_load    = 1'b1;
                    dec_o.writes_reg = 1'b1;
                end
                OP_STORE: begin
                    dec_o.alu_op     = ALU_ADD;
                    dec_o.alu_src    = 1'b1;
                    dec_o.is_store   = 1'b1;
                end
                OP_MOVE: begin
                    dec_o.alu_op     = ALU_PASS;
                    dec_o.writes_reg = 1'b1;
                end
                OP_BNE: begin
                    dec_o.alu_op     = ALU_PASS;
                    dec_o.is_branch  = 1'b1;
                end
                OP_SET: begin
                    dec_o.alu_op     = ALU_PASS;
                    dec_o.alu_src    = 1'b1;
                    dec_o.writes_reg = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB).
//   clk, reset            : clock, synchronous active-high reset
//   start, halt_req       : begin sequencing / stop after current retire
//   instr, instr_valid,
//   instr_ready           : opcode fetch handshake
//   zero, mem_ready       : ALU zero flag, data memory completion
//   alu_op, alu_src,
//   mem_read, mem_write,
//   mem_to_reg, reg_write,
//   pc_inc, branch_taken  : registered datapath strobes
//   busy, mem_err, retired: status (sticky timeout flag, retire counter)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | stopped; start -> FETCH and clears mem_err
// FETCH  | instr_ready high, latch opcode on instr_valid
// DECODE | one empty cycle
// EXEC   | alu_op/alu_src from opcode; BNE retires here
// MEM    | mem_read/mem_write held; counts wait cycles up to MEM_TMO
// WB     | reg_write, mem_to_reg (LOAD), pc_inc; retires
//
// All outputs are registered from the next state, so they line up with the
// current state without any input-to-output path. Retires decided by an input
// in the same cycle (BNE on zero, STORE on mem_ready) therefore show their
// pc_inc/branch_taken pulse in the cycle right after the retiring edge.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int ALUOPW  = 3,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [OPW-1:0]    instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [ALUOPW-1:0] alu_op,
    output logic              alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              pc_inc,
    output logic              branch_taken,
    output logic              busy,
    output logic              mem_err,
    output logic [CNT_W-1:0]  retired
);

    localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;

    state_e             state_q, state_d;
    logic [OPW-1:0]     opcode_q, opcode_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               pc_pulse_d, br_pulse_d;
    dec_t               dec;

    logic               instr_ready_q;
    logic [ALUOPW-1:0]  alu_op_q;
    logic               alu_src_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               mem_to_reg_q;
    logic               reg_write_q;
    logic               pc_inc_q;
    logic               branch_taken_q;
    logic               busy_q;

    // Decodes the latched opcode; it is stable whenever state_d is EXEC/MEM/WB.
    ctrl_decode #(.OPW(OPW)) u_decode (
        .instr_i (opcode_q),
        .dec_o   (dec)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        tmo_d      = tmo_q;
        mem_err_d  = mem_err_q;
        retired_d  = retired_q;
        retire     = 1'b0;
        pc_pulse_d = 1'b0;
        br_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    mem_err_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    opcode_d = instr;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec.is_branch) begin
                    retire     = 1'b1;
                    br_pulse_d = !zero;
                    pc_pulse_d = zero;
                end else if (dec.is_load || dec.is_store) begin
                    state_d = ST_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (dec.is_load) begin
                        state_d = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        pc_pulse_d = 1'b1;
                    end
                end else if (tmo_q == TMO_W'(MEM_TMO - 1)) begin
                    // Timed out: abandon the instruction without retiring it.
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WB: retire = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        if (retire) begin
            retired_d = retired_q + 1'b1;
            state_d   = halt_req ? ST_IDLE : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            opcode_q       <= '0;
            tmo_q          <= '0;
            mem_err_q      <= 1'b0;
            retired_q      <= '0;
            instr_ready_q  <= 1'b0;
            alu_op_q       <= ALUOPW'(ALU_PASS);
            alu_src_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            reg_write_q    <= 1'b0;
            pc_inc_q       <= 1'b0;
            branch_taken_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            tmo_q          <= tmo_d;
            mem_err_q      <= mem_err_d;
            retired_q      <= retired_d;
            instr_ready_q  <= (state_d == ST_FETCH);
            alu_op_q       <= (state_d == ST_EXEC) ? ALUOPW'(dec.alu_op) : ALUOPW'(ALU_PASS);
            alu_src_q      <= (state_d == ST_EXEC) && dec.alu_src;
            mem_read_q     <= (state_d == ST_MEM) && dec.is_load;
            mem_write_q    <= (state_d == ST_MEM) && dec.is_store;
            mem_to_reg_q   <= (state_d == ST_WB) && dec.is_load;
            reg_write_q    <= (state_d == ST_WB) && dec.writes_reg;
            pc_inc_q       <= (state_d == ST_WB) || pc_pulse_d;
            branch_taken_q <= br_pulse_d;
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign instr_ready  = instr_ready_q;
    assign alu_op       = alu_op_q;
    assign alu_src      = alu_src_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_to_reg   = mem_to_reg_q;
    assign reg_write    = reg_write_q;
    assign pc_inc       = pc_inc_q;
    assign branch_taken = branch_taken_q;
    assign busy         = busy_q;
    assign mem_err      = mem_err_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Testbench for ctrl_fsm: table of instructions run through a per-cycle
// timeline; expected output words are queued when stimulus is driven and
// compared on the falling edge.
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int MEM_TMO = 15;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, instr_valid, zero, mem_ready;
    logic [2:0]  instr;
    logic        instr_ready, alu_src, mem_read, mem_write, mem_to_reg;
    logic        reg_write, pc_inc, branch_taken, busy, mem_err;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    always #5 clk = ~clk;

    ctrl_fsm #(.OPW(3), .ALUOPW(3), .MEM_TMO(MEM_TMO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .pc_inc(pc_inc), .branch_taken(branch_taken),
        .busy(busy), .mem_err(mem_err), .retired(retired)
    );

    typedef struct packed {
        logic        instr_ready;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        pc_inc;
        logic        branch_taken;
        logic        busy;
        logic        mem_err;
        logic [15:0] retired;
    } out_t;

    typedef struct {
        logic [2:0] op;
        logic       z;
        int         rdy_at;   // MEM cycle (1-based) with mem_ready, 0 = never
        logic       halt;     // halt_req in the retire cycle
        int         gap;      // FETCH cycles without instr_valid first
        int         rst_at;   // MEM cycle with reset asserted, 0 = none
        logic [2:0] alu;      // expected alu_op in EXEC
        logic       src;      // expected alu_src in EXEC
    } vec_t;

    out_t        exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_ret;
    logic        m_err, pend_pc, pend_br, m_idle;
    vec_t        vecs[18];

    function automatic out_t dut_out();
        out_t o;
        o.instr_ready  = instr_ready;
        o.alu_op       = alu_op;
        o.alu_src      = alu_src;
        o.mem_read     = mem_read;
        o.mem_write    = mem_write;
        o.mem_to_reg   = mem_to_reg;
        o.reg_write    = reg_write;
        o.pc_inc       = pc_inc;
        o.branch_taken = branch_taken;
        o.busy         = busy;
        o.mem_err      = mem_err;
        o.retired      = retired;
        return o;
    endfunction

    task automatic chk(input logic ok, input string t);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: rdy=%b alu=%b src=%b rd=%b wr=%b m2r=%b rw=%b pc=%b br=%b busy=%b err=%b ret=%0d",
                     t, instr_ready, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
                     reg_write, pc_inc, branch_taken, busy, mem_err, retired);
        end
    endtask

    always @(negedge clk) begin
        out_t  e, a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = dut_out();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got rdy=%b alu=%b src=%b rd=%b wr=%b m2r=%b rw=%b pc=%b br=%b busy=%b err=%b ret=%0d | exp rdy=%b alu=%b src=%b rd=%b wr=%b m2r=%b rw=%b pc=%b br=%b busy=%b err=%b ret=%0d",
                         t, a.instr_ready, a.alu_op, a.alu_src, a.mem_read, a.mem_write, a.mem_to_reg,
                         a.reg_write, a.pc_inc, a.branch_taken, a.busy, a.mem_err, a.retired,
                         e.instr_ready, e.alu_op, e.alu_src, e.mem_read, e.mem_write, e.mem_to_reg,
                         e.reg_write, e.pc_inc, e.branch_taken, e.busy, e.mem_err, e.retired);
            end
        end
    end

    function automatic vec_t mkv(logic [2:0] op, logic z, int rdy_at, logic halt,
                                 int gap, int rst_at, logic [2:0] alu, logic src);
        vec_t v;
        v.op = op; v.z = z; v.rdy_at = rdy_at; v.halt = halt;
        v.gap = gap; v.rst_at = rst_at; v.alu = alu; v.src = src;
        return v;
    endfunction

    // Default output word for the coming cycle; consumes pending retire pulses.
    task automatic base(output out_t e, input logic bsy);
        e              = '0;
        e.alu_op       = 3'b111;
        e.busy         = bsy;
        e.mem_err      = m_err;
        e.retired      = m_ret;
        e.pc_inc       = pend_pc;
        e.branch_taken = pend_br;
        pend_pc        = 1'b0;
        pend_br        = 1'b0;
    endtask

    task automatic cyc(input logic rst, input logic st, input logic iv, input logic [2:0] ins,
                       input logic z, input logic mr, input logic hr, input out_t e, input string t);
        reset       = rst;
        start       = st;
        instr_valid = iv;
        instr       = ins;
        zero        = z;
        mem_ready   = mr;
        halt_req    = hr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // IDLE cycle; instr_valid, mem_ready and halt_req are driven to show they are ignored.
    task automatic idle_cyc(input logic st, input string t);
        out_t e;
        base(e, 1'b0);
        cyc(1'b0, st, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, e, t);
        if (st) begin
            m_err  = 1'b0;
            m_idle = 1'b0;
        end
    endtask

    task automatic run_instr(input vec_t v, input string t);
        out_t e;
        logic rdy;
        logic is_ld, is_st;
        is_ld = (v.op == 3'b011);
        is_st = (v.op == 3'b100);
        for (int g = 0; g < v.gap; g++) begin
            base(e, 1'b1);
            e.instr_ready = 1'b1;
            cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, e, {t, "/fetch-wait"});
        end
        base(e, 1'b1);
        e.instr_ready = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, v.op, 1'b0, 1'b0, 1'b0, e, {t, "/fetch"});
        base(e, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, ~v.op, 1'b0, 1'b1, 1'b0, e, {t, "/decode"});
        base(e, 1'b1);
        e.alu_op  = v.alu;
        e.alu_src = v.src;
        if (v.op == 3'b110) begin
            cyc(1'b0, 1'b0, 1'b0, 3'b000, v.z, 1'b0, v.halt, e, {t, "/exec-bne"});
            m_ret++;
            pend_pc = v.z;
            pend_br = !v.z;
            m_idle  = v.halt;
            return;
        end
        cyc(1'b0, 1'b0, 1'b0, 3'b000, v.z, 1'b1, 1'b0, e, {t, "/exec"});
        if (is_ld || is_st) begin
            for (int i = 1; i <= MEM_TMO; i++) begin
                rdy = (i == v.rdy_at);
                base(e, 1'b1);
                e.mem_read  = is_ld;
                e.mem_write = is_st;
                if (i == v.rst_at) begin
                    cyc(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, e, $sformatf("%s/mem%0d-rst", t, i));
                    m_ret   = '0;
                    m_err   = 1'b0;
                    pend_pc = 1'b0;
                    pend_br = 1'b0;
                    m_idle  = 1'b1;
                    return;
                end
                cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, rdy, v.halt && rdy && is_st, e,
                    $sformatf("%s/mem%0d", t, i));
                if (rdy && is_st) begin
                    m_ret++;
                    pend_pc = 1'b1;
                    m_idle  = v.halt;
                    return;
                end
                if (rdy) break;
                if (i == MEM_TMO) begin
                    chk(mem_err === 1'b1 && busy === 1'b0 && mem_write === 1'b0 &&
                        mem_read === 1'b0 && pc_inc === 1'b0 && retired === m_ret,
                        {t, "/timeout-expired"});
                    m_err  = 1'b1;
                    m_idle = 1'b1;
                    return;
                end
            end
        end
        base(e, 1'b1);
        e.reg_write  = 1'b1;
        e.mem_to_reg = is_ld;
        e.pc_inc     = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, v.halt, e, {t, "/wb"});
        m_ret++;
        m_idle = v.halt;
    endtask

    initial begin
        //              op      z     rdy      halt  gap rst alu     src
        vecs[0]  = mkv(3'b000, 1'b0, 0,       1'b0, 0,  0,  3'b000, 1'b0); // ADD
        vecs[1]  = mkv(3'b011, 1'b0, 3,       1'b0, 0,  0,  3'b000, 1'b1); // LOAD, ready in 3rd MEM cycle
        vecs[2]  = mkv(3'b001, 1'b1, 0,       1'b0, 2,  0,  3'b001, 1'b0); // RROT after fetch stall
        vecs[3]  = mkv(3'b010, 1'b0, 0,       1'b0, 0,  0,  3'b010, 1'b0); // NAND
        vecs[4]  = mkv(3'b101, 1'b0, 0,       1'b0, 1,  0,  3'b111, 1'b0); // MOVE
        vecs[5]  = mkv(3'b111, 1'b0, 0,       1'b0, 0,  0,  3'b111, 1'b1); // SET
        vecs[6]  = mkv(3'b100, 1'b0, 1,       1'b0, 0,  0,  3'b000, 1'b1); // STORE, immediate ready
        vecs[7]  = mkv(3'b110, 1'b0, 0,       1'b0, 0,  0,  3'b111, 1'b0); // BNE taken
        vecs[8]  = mkv(3'b110, 1'b1, 0,       1'b0, 0,  0,  3'b111, 1'b0); // BNE not taken
        vecs[9]  = mkv(3'b011, 1'b0, 1,       1'b0, 0,  0,  3'b000, 1'b1); // LOAD, immediate ready
        vecs[10] = mkv(3'b100, 1'b0, 0,       1'b0, 0,  0,  3'b000, 1'b1); // STORE timeout
        vecs[11] = mkv(3'b011, 1'b0, MEM_TMO, 1'b0, 0,  0,  3'b000, 1'b1); // LOAD, ready on last allowed cycle
        vecs[12] = mkv(3'b111, 1'b0, 0,       1'b1, 0,  0,  3'b111, 1'b1); // SET with halt in WB
        vecs[13] = mkv(3'b110, 1'b0, 0,       1'b1, 0,  0,  3'b111, 1'b0); // BNE taken with halt
        vecs[14] = mkv(3'b100, 1'b0, 2,       1'b1, 0,  0,  3'b000, 1'b1); // STORE with halt at retire
        vecs[15] = mkv(3'b000, 1'b1, 0,       1'b0, 0,  0,  3'b000, 1'b0); // ADD
        vecs[16] = mkv(3'b011, 1'b0, 0,       1'b0, 0,  2,  3'b000, 1'b1); // LOAD, reset in MEM
        vecs[17] = mkv(3'b000, 1'b0, 0,       1'b0, 0,  0,  3'b000, 1'b0); // ADD after reset

        reset = 1'b1; start = 1'b0; halt_req = 1'b0; instr_valid = 1'b0;
        instr = 3'b000; zero = 1'b0; mem_ready = 1'b0;
        m_ret = '0; m_err = 1'b0; pend_pc = 1'b0; pend_br = 1'b0; m_idle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(busy === 1'b0 && mem_err === 1'b0 && retired === 16'd0 && alu_op === 3'b111 &&
            instr_ready === 1'b0 && alu_src === 1'b0 && mem_read === 1'b0 && mem_write === 1'b0 &&
            mem_to_reg === 1'b0 && reg_write === 1'b0 && pc_inc === 1'b0 && branch_taken === 1'b0,
            "reset-state");
        idle_cyc(1'b0, "reset");
        idle_cyc(1'b1, "start");
        foreach (vecs[k]) begin
            if (m_idle) begin
                idle_cyc(1'b0, $sformatf("v%0d/idle", k));
                idle_cyc(1'b1, $sformatf("v%0d/restart", k));
            end
            run_instr(vecs[k], $sformatf("v%0d", k));
        end
        base_tail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // One more FETCH cycle so the last retire's count and pulses are compared.
    task automatic base_tail();
        out_t e;
        base(e, 1'b1);
        e.instr_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, e, "tail");
    endtask

endmodule
